// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN_A = 2'd1,
        ARB_OWN_B = 2'd2
    } arb_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int unsigned ARB_STATS_W = 16;

    // Mux select implied by an owner state; non-owner states keep the current select.
    function automatic logic sel_for_state(arb_state_e st, logic cur_sel);
        logic sel;
        sel = cur_sel;
        if (st == ARB_OWN_A) begin
            sel = SEL_A;
        end else if (st == ARB_OWN_B) begin
            sel = SEL_B;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mux_2to1.sv
// Plain 2:1 word multiplexer; sel=0 picks in_a, sel=1 picks in_b.
module mux_2to1 #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  sel,
    output logic [DATA_WIDTH-1:0] out_y
);

    assign out_y = sel ? in_b : in_a;

endmodule

// File: rtl/mux_arb_2to1.sv
// Round-robin owner arbiter driving a shared mux_2to1 between requesters A and B.
// Define MUX_ARB_STATS_EN to add per-side beat counters (Beats_A/Beats_B/Stats_Clr).
module mux_arb_2to1
    import mux_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_HOLD   = 4
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Req_A,
    input  logic [DATA_WIDTH-1:0] Data_A,
    output logic                  Grant_A,
    input  logic                  Req_B,
    input  logic [DATA_WIDTH-1:0] Data_B,
    output logic                  Grant_B,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic [DATA_WIDTH-1:0] Out_Data,
`ifdef MUX_ARB_STATS_EN
    output logic [ARB_STATS_W-1:0] Beats_A,
    output logic [ARB_STATS_W-1:0] Beats_B,
    input  logic                   Stats_Clr,
`endif
    output logic                  Select
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              select_q, select_d;
    logic              last_owner_q, last_owner_d;
    logic              own_a, own_b;
    logic              beat;
    logic              hold_expired;

    assign own_a = (state_q == ARB_OWN_A);
    assign own_b = (state_q == ARB_OWN_B);

    assign Out_Valid = (own_a && Req_A) || (own_b && Req_B);
    assign Grant_A   = own_a && Req_A && Out_Ready;
    assign Grant_B   = own_b && Req_B && Out_Ready;
    assign Select    = select_q;

    assign beat = Out_Valid && Out_Ready;
    // ">=" rather than "==" so a counter saturated during an uncontested burst
    // still yields on the next beat once the other side starts requesting.
    assign hold_expired = beat && (hold_cnt_q >= HOLD_LAST);

    mux_2to1 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .in_a  (Data_A),
        .in_b  (Data_B),
        .sel   (select_q),
        .out_y (Out_Data)
    );

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (Req_A && Req_B) begin
                    state_d = (last_owner_q == SEL_A) ? ARB_OWN_B : ARB_OWN_A;
                end else if (Req_A) begin
                    state_d = ARB_OWN_A;
                end else if (Req_B) begin
                    state_d = ARB_OWN_B;
                end
            end
            ARB_OWN_A: begin
                if (!Req_A) begin
                    state_d      = Req_B ? ARB_OWN_B : ARB_IDLE;
                    last_owner_d = SEL_A;
                end else if (hold_expired && Req_B) begin
                    state_d      = ARB_OWN_B;
                    last_owner_d = SEL_A;
                end
            end
            ARB_OWN_B: begin
                if (!Req_B) begin
                    state_d      = Req_A ? ARB_OWN_A : ARB_IDLE;
                    last_owner_d = SEL_B;
                end else if (hold_expired && Req_A) begin
                    state_d      = ARB_OWN_A;
                    last_owner_d = SEL_B;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_d != state_q) begin
            hold_cnt_d = '0;
        end else if (beat && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    assign select_d = sel_for_state(state_d, select_q);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ARB_IDLE;
            hold_cnt_q   <= '0;
            select_q     <= SEL_A;
            last_owner_q <= SEL_B;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            select_q     <= select_d;
            last_owner_q <= last_owner_d;
        end
    end

`ifdef MUX_ARB_STATS_EN
    localparam logic [ARB_STATS_W-1:0] STATS_MAX = '1;

    logic [ARB_STATS_W-1:0] beats_a_q, beats_b_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            beats_a_q <= '0;
            beats_b_q <= '0;
        end else if (Stats_Clr) begin
            beats_a_q <= '0;
            beats_b_q <= '0;
        end else begin
            if (Grant_A && (beats_a_q != STATS_MAX)) begin
                beats_a_q <= beats_a_q + 1'b1;
            end
            if (Grant_B && (beats_b_q != STATS_MAX)) begin
                beats_b_q <= beats_b_q + 1'b1;
            end
        end
    end

    assign Beats_A = beats_a_q;
    assign Beats_B = beats_b_q;
`endif

    grant_onehot_a : assert property (@(posedge Clk) disable iff (!Reset_n)
        !(Grant_A && Grant_B));

endmodule

// File: doc/mux_arb_2to1.md
# mux_arb_2to1

Round-robin arbiter that shares one `mux_2to1` datapath between two requesters, A and B, and drives its `Select` line. Each requester presents a word under a valid/grant handshake. The arbiter picks an owner, steers that requester's data to a single downstream port, and hands off ownership fairly. A hold limit stops either side from starving the other. It sits between two producers and one consumer in any datapath that currently hard-wires a 2:1 mux select.

## Interface
- `DATA_WIDTH`, 8, width of each data word.
- `MAX_HOLD`, 4, maximum number of consecutive beats granted to one owner while the other side is requesting (≥1).
- `Clk` in 1: single clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Req_A` in 1: requester A has a valid word.
- `Data_A` in DATA_WIDTH: A's word; must be stable while `Req_A`=1 and not yet granted.
- `Grant_A` out 1: A's word is accepted this cycle.
- `Req_B`, `Data_B`, `Grant_B`: same as A, for requester B.
- `Out_Valid` out 1: `Out_Data` holds a valid word.
- `Out_Ready` in 1: the consumer accepts the word this cycle.
- `Out_Data` out DATA_WIDTH: the selected word.
- `Select` out 1: current mux select; 0=A, 1=B. Registered.

## Operation
- States:
  - IDLE: no owner.
  - OWN_A: Select=0.
  - OWN_B: Select=1.
- A transfer ("beat") happens when `Out_Valid` && `Out_Ready`.
- Combinational outputs:
  - `Out_Valid` = (OWN_A && Req_A) || (OWN_B && Req_B).
  - `Grant_A` = OWN_A && Req_A && Out_Ready. `Grant_B` is the mirror.
  - `Out_Data` = `mux_2to1(Data_A, Data_B, Select)`.
- IDLE transitions:
  - Only one side requesting: go to that side's OWN state.
  - Both requesting: go to the side ≠ `last_owner`.
  - Neither requesting: stay in IDLE.
- OWN_X transitions, evaluated each cycle:
  - Req_X=0 and the other side is requesting: switch to the other side's OWN state.
  - Req_X=0 and the other side is idle: go to IDLE.
  - A beat occurs, hold_cnt+1 == MAX_HOLD, and the other side is requesting: switch to the other side after the beat.
  - Otherwise: stay.
- hold_cnt:
  - Width is $clog2(MAX_HOLD+1).
  - Cleared on every state change.
  - Increments on each beat.
  - Saturates at MAX_HOLD; it never wraps.
  - While the other side is idle, the owner keeps the grant indefinitely.
- `last_owner` updates to X when leaving OWN_X.
- `Select` holds its last value in IDLE, so it never glitches while no owner exists.
- Requester rules:
  - Once `Req_X` is raised, it must stay high until its grant arrives.
  - A requester that drops Req early loses ownership with no penalty.
- Reset values:
  - state=IDLE, Select=0, last_owner=B (so A wins the first tie), hold_cnt=0.
  - Outputs during reset: Out_Valid=0, Grant_A=Grant_B=0.

## Timing
- Arbitration latency: Req raised in cycle N → ownership registered at edge N+1 → earliest Grant in cycle N+1.
- Throughput: one beat per cycle while the owner holds Req and Out_Ready=1.
- Handoff costs zero bubble cycles when both sides request: the beat at MAX_HOLD and the first beat of the new owner are in consecutive cycles.
- Out_Ready=0 stalls the owner. hold_cnt does not advance and ownership does not change, except when the owner drops Req.
- Simultaneous Req_A/Req_B rise in IDLE: resolved by `last_owner`.
- Reset asserted mid-burst:
  - All state clears immediately (asynchronous).
  - Any in-flight word is not granted.
  - After release, arbitration restarts from IDLE.
- MAX_HOLD=1: strict alternation when both sides request continuously.

## Configuration
- `MUX_ARB_STATS_EN` defined adds four things:
  - Output `Beats_A` (16 bits): counts Grant_A beats, saturating at 16'hFFFF, cleared by reset.
  - Output `Beats_B` (16 bits): the same for B.
  - Input `Stats_Clr` (1 bit): synchronous clear of both counters; it takes priority over a same-cycle increment.
  - The ports above exist only when the macro is defined.
- Not defined: no counters and no stats ports. Arbitration behaviour is identical.

## Structure
- Shared package `mux_arb_pkg` holds:
  - The state enum: `ARB_IDLE`, `ARB_OWN_A`, `ARB_OWN_B`.
  - Constant `SEL_A`=1'b0 and `SEL_B`=1'b1.
  - Stats width constant `ARB_STATS_W`=16.
- Sub-module: the existing `mux_2to1` (DATA_WIDTH passed through) implements the `Out_Data` steering. The FSM and hold counter stay in `mux_arb_2to1`.

## Test plan
- Reset, then Req_A=1 with Data_A=8'h3C and Out_Ready=1 → cycle 1: Select=0, Out_Valid=1, Out_Data=8'h3C, Grant_A=1.
- Both Req held high from IDLE after reset, MAX_HOLD=4, Out_Ready=1 → Grant_A for 4 beats, then Grant_B for 4 beats, alternating with no bubble cycles.
- Owner A bursting, Out_Ready=0 for 3 cycles → Grant_A=0 and hold_cnt frozen, Select stays 0; the burst resumes when Ready returns.
- Only Req_B active for 10 beats → B keeps ownership for all 10 beats; no handoff, since A is idle.
- Reset_n pulsed low mid-burst in OWN_B → Out_Valid/Grant_B drop at once; after release, Select=0 and state=IDLE.
- With `MUX_ARB_STATS_EN`: 5 A beats and 3 B beats → Beats_A=5 and Beats_B=3; Stats_Clr for 1 cycle → both read 0 on the next cycle.
